// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request port with a fixed-latency, one-cycle response strobe.
// Errors (misaligned or out-of-range addresses) return resp_err=1 with zero data and never touch storage.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [`ADDR_LEN-1:0] req_addr,
  input  logic [`DATA_LEN-1:0] req_wdata,
  input  logic [3:0]           req_be,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [`DATA_LEN-1:0] resp_rdata,
  output logic                 resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [`ADDR_LEN-1:0]   lat_addr;
  logic [`DATA_LEN-1:0]   lat_wdata;
  logic [3:0]             lat_be;
  logic                   lat_write;
  logic                   lat_err;
  logic [IDX_W-1:0]       lat_idx;
  logic [`DATA_LEN-1:0]   mem [DEPTH_WORDS];

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only while idle and out of reset. resp_valid is a single-cycle
  // strobe with no backpressure; resp_rdata/resp_err are zero whenever it is low.
  assign req_ready = rst && (state == IDLE);

  assign lat_err = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(DEPTH_WORDS));
  assign lat_idx = lat_addr[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      lat_write  <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[IDX_W'(i)] <= '0;
      end
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            lat_write <= req_write;
            if (LATENCY > 0) begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          // Counter holds at zero for one cycle before the response is formed.
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
          if (lat_err) begin
            resp_err <= 1'b1;
          end else if (lat_write) begin
            for (int b = 0; b < 4; b++) begin
              if (lat_be[b]) begin
                mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
              end
            end
          end else begin
            resp_rdata <= mem[lat_idx];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed literal cases plus randomized traffic against a cycle-counted reference model.
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be    = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        v0 = 1'b0;
  logic        w0 = 1'b0;
  logic [31:0] a0 = '0;
  logic [31:0] d0 = '0;
  logic [3:0]  be0 = '0;
  logic        rdy0, rv0, er0;
  logic [31:0] rd0;

  int checks   = 0;
  int failures = 0;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_write(w0),
    .req_addr(a0), .req_wdata(d0), .req_be(be0), .req_ready(rdy0),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // scoreboard: reference model of memory and response timing
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int          due;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          cyc = 0;
  int          next_free = 0;
  bit          armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic        exp_v, exp_er, exp_rdy;
    logic [31:0] exp_rd;
    req_t        r;
    exp_v  = 1'b0;
    exp_er = 1'b0;
    exp_rd = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      exp_v = 1'b1;
      if (r.a[1:0] != 2'b00 || (r.a >> 2) >= 32'(DEPTH)) begin
        exp_er = 1'b1;
      end else if (r.w) begin
        for (int b = 0; b < 4; b++) begin
          if (r.be[b]) model_mem[r.a >> 2][8*b +: 8] = r.d[8*b +: 8];
        end
      end else begin
        exp_rd = model_mem[r.a >> 2];
      end
    end
    exp_rdy = rst && (cyc >= next_free);
    if (armed) begin
      check("model_resp_valid", resp_valid, exp_v);
      check("model_resp_rdata", resp_rdata, exp_rd);
      check("model_resp_err", resp_err, exp_er);
      check("model_req_ready", req_ready, exp_rdy);
    end
    if (!rst) begin
      armed = 1'b1;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      next_free = cyc + 1;
    end else if (armed && req_valid && exp_rdy) begin
      r.w = req_write; r.a = req_addr; r.d = req_wdata; r.be = req_be;
      r.due = cyc + LAT + 2;
      exp_q.push_back(r);
      next_free = cyc + LAT + 2;
    end
  end

  // driver tasks: all start and end just after a rising edge
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_seen", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 0;
    @(negedge clk);
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("resp_seen", resp_valid, 1);
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic abort_req(input logic [31:0] a, input logic [31:0] d, input int wait_cyc);
    int pulses;
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_be = 4'hF;
    @(negedge clk);
    check("abort_ready_before", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (wait_cyc) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    pulses = 0;
    @(negedge clk);
    check("abort_ready_after", req_ready, 1);
    if (resp_valid) pulses++;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("abort_no_resp", pulses, 0);
    @(posedge clk); #1;
  endtask

  task automatic req0(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_er);
    v0 = 1'b1; w0 = w; a0 = a; d0 = d; be0 = be;
    @(negedge clk);
    check("l0_ready_idle", rdy0, 1);
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk);
    check("l0_ready_in_resp", rdy0, 0);
    check("l0_valid_early", rv0, 0);
    @(negedge clk);
    check("l0_valid", rv0, 1);
    check("l0_rdata", rd0, exp_rd);
    check("l0_err", er0, exp_er);
    check("l0_ready_next", rdy0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("l0_valid_single", rv0, 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 32'($urandom_range(0, 15)) << 2;
      6:       return 32'($urandom_range(0, DEPTH - 1)) << 2;
      7:       return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      8:       return 32'(DEPTH * 4) + (32'($urandom_range(0, 3)) << 2);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, acc, pulses;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_ready", req_ready, 0);
    check("reset_valid", resp_valid, 0);
    check("reset_rdata", resp_rdata, 0);
    check("reset_err", resp_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1);
    check("l0_ready_after_reset", rdy0, 1);
    @(posedge clk); #1;

    // zero-latency instance
    req0(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    req0(1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    req0(1'b0, 32'h3C, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    req0(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1);
    req0(1'b0, 32'h2, 32'h0, 4'h0, 32'h0, 1'b1);

    // directed literal cases on the LATENCY=2 instance
    do_req(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("wr8_latency", lat, 3);
    check("wr8_err", er, 0);
    check("wr8_rdata", rd, 0);
    do_req(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    check("rd8_data", rd, 32'hDEADBEEF);
    do_req(1'b1, 32'h4, 32'h11223344, 4'hF, rd, er, lat);
    do_req(1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    do_req(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
    check("rd4_merged", rd, 32'h11BB33DD);
    do_req(1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    check("wr6_err", er, 1);
    do_req(1'b0, 32'h6, 32'h0, 4'h0, rd, er, lat);
    check("rd6_err", er, 1);
    check("rd6_rdata", rd, 0);
    do_req(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
    check("rd4_unchanged", rd, 32'h11BB33DD);
    do_req(1'b1, 32'(DEPTH * 4), 32'h12345678, 4'hF, rd, er, lat);
    check("wr_oor_err", er, 1);
    do_req(1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, rd, er, lat);
    check("rd_oor_err", er, 1);
    check("rd_oor_rdata", rd, 0);
    do_req(1'b1, 32'h8, 32'h00000000, 4'h0, rd, er, lat);
    check("be0_err", er, 0);
    do_req(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    check("be0_unchanged", rd, 32'hDEADBEEF);

    // reset while waiting aborts the write and clears storage
    abort_req(32'hC, 32'h12345678, 1);
    do_req(1'b0, 32'hC, 32'h0, 4'h0, rd, er, lat);
    check("abort_rdC", rd, 0);
    do_req(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    check("abort_rd8_zeroed", rd, 0);

    // continuous req_valid: one acceptance per LAT+2 cycles
    acc = 0;
    pulses = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_write = 1'($urandom_range(0, 1));
      req_addr  = rand_addr();
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      @(negedge clk);
      if (req_valid && req_ready) acc++;
      if (resp_valid) pulses++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("hold_accepts", acc, 5);
    check("hold_pulses", pulses, 4);
    repeat (4) @(posedge clk);
    #1;

    // randomized traffic, checked by the model
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 19) == 0) begin
        abort_req(32'($urandom_range(0, 15)) << 2, $urandom, int'($urandom_range(0, LAT)));
      end else begin
        do_req(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom), rd, er, lat);
        check("rand_latency", lat, LAT + 1);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (6) @(posedge clk);
    #1;
    check("model_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
